nn_layer_seq: RTL and testbench
===============================

Name: nn_layer_seq

Overview:
- Parametrised, time-multiplexed fully-connected layer for the fixed-point neural network.
- Holds NIN weights plus one bias per node in per-node shift registers, loaded serially from the shared weight bus.
- On start, evaluates all NOUT nodes in parallel, one input per cycle. It then saturates, applies the selected activation and raises a done pulse.
- Layers are chained in the top level: one layer's y feeds the next layer's x, and done drives the next layer's start.

Parameters:
- N, 16, data word width (signed two's complement).
- FRAC, 8, fractional bits of the fixed-point format (0 < FRAC < N).
- NIN, 4, inputs per node (>=1).
- NOUT, 3, nodes in the layer (>=1).
- ACT, 0, activation: 0 = linear, 1 = ReLU.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- we  in  NOUT  per-node weight shift enable; bit j selects node j.
- bus  in  N  signed weight/bias word to shift in.
- start  in  1  request evaluation of the layer.
- x  in  N*NIN  input vector; x[0] in the LSBs.
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle pulse when y is updated.
- y  out  N*NOUT  registered node outputs; node 0 in the LSBs.
- w_all  out  N*(NIN+1)*NOUT  all weights and biases for backprop; node 0 in the LSBs, each node packed as w[0]..w[NIN-1], then bias.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy=0, done=0, y=0, all weights and biases 0, accumulators 0, counter 0. Asserting reset mid-evaluation aborts it; no done is produced.
- Weight load:
  - Each node j has NIN+1 words, r[0..NIN]; r[NIN] is the bias.
  - On an edge with we[j]=1 in IDLE: r[NIN] <= bus and r[i] <= r[i+1] for i < NIN.
  - After NIN+1 writes, the first word written sits in r[0] and the last in the bias.
  - Several we bits high load the same word into several nodes.
  - we is ignored while busy=1.
- FSM has three states: IDLE, MAC, OUT.
  - IDLE:
    - start=1 at edge E0 captures x into an internal register and loads acc[j] <= sign-extended bias[j] << FRAC.
    - The same edge sets cnt=0 and moves to MAC, with busy=1 from E0.
    - If we and start are both high at E0, the weight shift also happens at E0, and the computation uses the post-shift weights.
  - MAC: on each edge acc[j] += xreg[cnt] * r_j[cnt], using the full 2N-bit signed product. cnt increments; after NIN MAC edges (E1..E_NIN) the FSM moves to OUT.
  - OUT, at edge E_NIN+1:
    - y[j] <= act(sat(acc[j] >>> FRAC)), with done=1 and busy=0.
    - The FSM returns to IDLE; done falls at the next edge.
- Latency: start sampled at E0 gives y and done valid after E_NIN+1, i.e. NIN+1 cycles.
- Back-to-back: start may be high in the cycle done=1; that start is accepted. start while busy=1 is ignored, not queued.
- Arithmetic:
  - Accumulator width ACCW = 2N + clog2(NIN+1) + 1, so no internal overflow is possible.
  - >>> FRAC is an arithmetic shift (rounds toward -inf).
  - sat clamps to [-2^(N-1), 2^(N-1)-1].
  - act: ACT=0 is identity; ACT=1 maps negative values to 0.
- y holds its value between evaluations.
- w_all is continuously driven from the registers and reflects writes on the next cycle.

Test Plan:
(All cases use N=16, FRAC=8, NIN=4, NOUT=3; raw 256 = 1.0.)
- Reset mid-MAC: start, then rst=0 for 1 cycle at E2 → busy=0, done=0, y=0, w_all=0 immediately; no done pulse follows.
- Load/compute:
  - Stimulus: shift node0 with 256, 128, -256, 512, bias 64; x = {256, 512, 256, 128}; pulse start.
  - Required: busy for 5 cycles; done after exactly NIN+1 edges; y0 = 576 (2.25).
  - w_all node0 = {256, 128, -256, 512, 64}.
- Saturation: all node1 weights 25600, x all 25600, bias 0 → y1 = 32767. Negating the weights gives y1 = -32768 with ACT=0.
- ReLU and floor:
  - ACT=1, node2 result -384 → y2 = 0; the same stimulus with ACT=0 → -384.
  - w=1, x=-128, bias 0, other terms 0 → y = -1 (floor).
- Handshake edge cases:
  - start held high through busy → only one evaluation per accept.
  - start asserted in the done cycle → a second done after NIN+1 more edges.
  - we pulses while busy → w_all unchanged.
  - we and start together in IDLE → result uses the shifted weights.

Source files
------------

// File: rtl/nn_layer_seq_if.sv
// Handshake and data bundle for one time-multiplexed fully-connected layer.
// The master drives the weight bus, the start request and the input vector. The slave returns status, outputs and the weight image.
interface nn_layer_seq_if #(
  parameter int N    = 16,
  parameter int NIN  = 4,
  parameter int NOUT = 3
);
  logic [NOUT-1:0]           we;
  logic signed [N-1:0]       bus;
  logic                      start;
  logic [N*NIN-1:0]          x;
  logic                      busy;
  logic                      done;
  logic [N*NOUT-1:0]         y;
  logic [N*(NIN+1)*NOUT-1:0] w_all;

  modport master (output we, bus, start, x, input busy, done, y, w_all);
  modport slave  (input we, bus, start, x, output busy, done, y, w_all);
endinterface

// File: rtl/nn_layer_seq.sv
// Fully-connected layer with serially loaded weights. All nodes evaluate in parallel, taking one input per cycle.
// The result is saturated and passed through the activation before it is registered on y.
module nn_layer_seq #(
  parameter int N    = 16,
  parameter int FRAC = 8,
  parameter int NIN  = 4,
  parameter int NOUT = 3,
  parameter int ACT  = 0
) (
  input logic          clk,
  input logic          rst,
  nn_layer_seq_if.slave io
);
  // state | meaning
  // IDLE  | weights loadable, waiting for start
  // MAC   | one multiply-accumulate per node per cycle, cnt selects the input
  // OUT   | saturate, activate, register y, pulse done

  localparam int ACCW = 2*N + $clog2(NIN+1) + 1;
  localparam int IW   = (NIN > 1) ? $clog2(NIN) : 1;
  localparam logic signed [N-1:0] YMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] YMIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                 state, state_nx;
  logic [IW-1:0]          cnt;
  logic signed [N-1:0]    w    [NOUT][NIN];
  logic signed [N-1:0]    b    [NOUT];
  logic signed [N-1:0]    xreg [NIN];
  logic signed [ACCW-1:0] acc  [NOUT];
  logic signed [2*N-1:0]  prod [NOUT];
  logic signed [ACCW-1:0] sh   [NOUT];
  logic signed [N-1:0]    res  [NOUT];
  logic signed [N-1:0]    yreg [NOUT];
  logic                   done_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (io.start) state_nx = MAC;
      MAC:     if (cnt == IW'(NIN-1)) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    for (int j = 0; j < NOUT; j++) begin
      prod[j] = '0;
      sh[j]   = '0;
      res[j]  = '0;
    end
    for (int j = 0; j < NOUT; j++) begin
      prod[j] = xreg[cnt] * w[j][cnt];
      sh[j]   = acc[j] >>> FRAC;
      if (sh[j] > ACCW'(YMAX))      res[j] = YMAX;
      else if (sh[j] < ACCW'(YMIN)) res[j] = YMIN;
      else                          res[j] = sh[j][N-1:0];
      if (ACT == 1 && res[j][N-1]) res[j] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      done_r <= 1'b0;
      for (int j = 0; j < NOUT; j++) begin
        b[j]    <= '0;
        acc[j]  <= '0;
        yreg[j] <= '0;
        for (int i = 0; i < NIN; i++) w[j][i] <= '0;
      end
      for (int i = 0; i < NIN; i++) xreg[i] <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          for (int j = 0; j < NOUT; j++) begin
            if (io.we[j]) begin
              b[j]         <= io.bus;
              w[j][NIN-1]  <= b[j];
              for (int i = 0; i < NIN-1; i++) w[j][i] <= w[j][i+1];
            end
          end
          if (io.start) begin
            cnt <= '0;
            for (int i = 0; i < NIN; i++) xreg[i] <= io.x[i*N +: N];
            // a simultaneous shift puts bus into the bias slot, so seed from it
            for (int j = 0; j < NOUT; j++)
              acc[j] <= ACCW'(io.we[j] ? io.bus : b[j]) <<< FRAC;
          end
        end
        MAC: begin
          cnt <= cnt + 1'b1;
          for (int j = 0; j < NOUT; j++) acc[j] <= acc[j] + ACCW'(prod[j]);
        end
        OUT: begin
          done_r <= 1'b1;
          for (int j = 0; j < NOUT; j++) yreg[j] <= res[j];
        end
        default: ;
      endcase
    end
  end

  assign io.busy = (state != IDLE);
  assign io.done = done_r;

  for (genvar j = 0; j < NOUT; j++) begin : g_node
    assign io.y[j*N +: N] = yreg[j];
    for (genvar i = 0; i < NIN; i++) begin : g_w
      assign io.w_all[(j*(NIN+1)+i)*N +: N] = w[j][i];
    end
    assign io.w_all[(j*(NIN+1)+NIN)*N +: N] = b[j];
  end
endmodule

// File: tb/tb_nn_layer_seq.sv
// Directed bench for nn_layer_seq. One linear and one ReLU instance share the same stimulus.
module tb_nn_layer_seq;
  typedef logic [4:0][15:0] nodew_t;
  typedef struct packed {
    nodew_t [2:0]      wt;
    logic [3:0][15:0]  xv;
    logic [2:0][15:0]  ya;
    logic [2:0][15:0]  yb;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs [4];

  always #5 clk = ~clk;

  nn_layer_seq_if #(.N(16), .NIN(4), .NOUT(3)) io0 ();
  nn_layer_seq_if #(.N(16), .NIN(4), .NOUT(3)) io1 ();

  assign io1.we    = io0.we;
  assign io1.bus   = io0.bus;
  assign io1.start = io0.start;
  assign io1.x     = io0.x;

  nn_layer_seq #(.N(16), .FRAC(8), .NIN(4), .NOUT(3), .ACT(0)) dut0 (.clk(clk), .rst(rst), .io(io0));
  nn_layer_seq #(.N(16), .FRAC(8), .NIN(4), .NOUT(3), .ACT(1)) dut1 (.clk(clk), .rst(rst), .io(io1));

  function automatic nodew_t nw(int a, int b, int c, int d, int e);
    nodew_t r;
    r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(d); r[4] = 16'(e);
    return r;
  endfunction

  function automatic logic [3:0][15:0] xs(int a, int b, int c, int d);
    logic [3:0][15:0] r;
    r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(d);
    return r;
  endfunction

  function automatic logic [2:0][15:0] ys(int a, int b, int c);
    logic [2:0][15:0] r;
    r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [239:0] a, input logic [239:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic load_node(input int j, input nodew_t wv);
    for (int k = 0; k < 5; k++) begin
      io0.we  = 3'(1 << j);
      io0.bus = wv[k];
      @(posedge clk); #1;
    end
    io0.we = '0;
  endtask

  task automatic load_all(input nodew_t [2:0] wt);
    for (int j = 0; j < 3; j++) load_node(j, wt[j]);
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = io0.busy ? 1 : 0;
    while (!io0.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (io0.busy) bcnt++;
    end
  endtask

  task automatic run_eval(input logic [63:0] xv, output int lat, output int bcnt);
    io0.x     = xv;
    io0.start = 1'b1;
    @(posedge clk); #1;
    io0.start = 1'b0;
    wait_done(lat, bcnt);
  endtask

  initial begin
    int lat, bcnt, n;
    nodew_t [2:0] wexp;

    vecs[0].wt = {nw(0,0,0,0,0), nw(0,0,0,0,0), nw(256,128,-256,512,64)};
    vecs[0].xv = xs(256,512,256,128);
    vecs[0].ya = ys(576,0,0);
    vecs[0].yb = ys(576,0,0);

    vecs[1].wt = {nw(-25600,-25600,-25600,-25600,0), nw(25600,25600,25600,25600,0), nw(256,0,0,0,0)};
    vecs[1].xv = xs(25600,25600,25600,25600);
    vecs[1].ya = ys(25600,32767,-32768);
    vecs[1].yb = ys(25600,32767,0);

    vecs[2].wt = {nw(256,0,0,0,0), nw(-25600,-25600,-25600,-25600,0), nw(0,1,0,0,0)};
    vecs[2].xv = xs(-384,-128,25600,25600);
    vecs[2].ya = ys(-1,-32768,-384);
    vecs[2].yb = ys(0,0,0);

    vecs[3].wt = {nw(0,0,0,0,-1), nw(-64,0,0,0,10), nw(128,128,128,128,-256)};
    vecs[3].xv = xs(256,256,256,256);
    vecs[3].ya = ys(256,-54,-1);
    vecs[3].yb = ys(256,0,0);

    io0.we = '0; io0.bus = '0; io0.start = 1'b0; io0.x = '0;
    #1;
    chk("reset_busy",  240'(io0.busy),  240'(0));
    chk("reset_done",  240'(io0.done),  240'(0));
    chk("reset_y",     240'(io0.y),     240'(0));
    chk("reset_w_all", io0.w_all,       240'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) begin
      load_all(vecs[k].wt);
      chk($sformatf("v%0d_w_all", k), io0.w_all, vecs[k].wt);
      run_eval(vecs[k].xv, lat, bcnt);
      chk($sformatf("v%0d_latency", k), 240'(lat),  240'(5));
      chk($sformatf("v%0d_busy_cycles", k), 240'(bcnt), 240'(5));
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("v%0d_lin_y%0d", k, j), 240'(io0.y[j*16 +: 16]), 240'(vecs[k].ya[j]));
        chk($sformatf("v%0d_relu_y%0d", k, j), 240'(io1.y[j*16 +: 16]), 240'(vecs[k].yb[j]));
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_falls", k), 240'(io0.done), 240'(0));
    end

    // start raised during the done cycle
    load_all(vecs[0].wt);
    run_eval(vecs[0].xv, lat, bcnt);
    chk("b2b_first_y0", 240'(io0.y[15:0]), 240'(16'd576));
    chk("b2b_first_done", 240'(io0.done), 240'(1));
    io0.x = xs(256,0,0,0);
    io0.start = 1'b1;
    @(posedge clk); #1;
    io0.start = 1'b0;
    wait_done(lat, bcnt);
    chk("b2b_second_latency", 240'(lat), 240'(5));
    chk("b2b_second_y0", 240'(io0.y[15:0]), 240'(16'd320));
    @(posedge clk); #1;

    // start held high across the whole busy window
    io0.x = vecs[0].xv;
    io0.start = 1'b1;
    repeat (5) @(posedge clk);
    #1 io0.start = 1'b0;
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (io0.done) n++;
    end
    chk("held_start_done_count", 240'(n), 240'(1));
    chk("held_start_y0", 240'(io0.y[15:0]), 240'(16'd576));

    // weight strobes during evaluation must be dropped
    io0.start = 1'b1;
    @(posedge clk); #1;
    io0.start = 1'b0;
    io0.we = 3'b111;
    io0.bus = 16'h1234;
    repeat (2) @(posedge clk);
    #1 io0.we = '0;
    wait_done(lat, bcnt);
    chk("busy_we_w_all", io0.w_all, vecs[0].wt);
    chk("busy_we_y0", 240'(io0.y[15:0]), 240'(16'd576));
    @(posedge clk); #1;

    // shift and start on the same edge: node0 becomes {128,-256,512,64,100}
    io0.we = 3'b001;
    io0.bus = 16'd100;
    io0.x = vecs[0].xv;
    io0.start = 1'b1;
    @(posedge clk); #1;
    io0.we = '0;
    io0.start = 1'b0;
    wait_done(lat, bcnt);
    wexp = vecs[0].wt;
    wexp[0] = nw(128,-256,512,64,100);
    chk("we_start_w_all", io0.w_all, wexp);
    chk("we_start_y0", 240'(io0.y[15:0]), 240'(16'd260));
    chk("we_start_latency", 240'(lat), 240'(5));
    @(posedge clk); #1;

    // reset asserted in the middle of MAC
    io0.start = 1'b1;
    @(posedge clk); #1;
    io0.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_busy",  240'(io0.busy), 240'(0));
    chk("midrst_done",  240'(io0.done), 240'(0));
    chk("midrst_y",     240'(io0.y),    240'(0));
    chk("midrst_w_all", io0.w_all,      240'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (io0.done || io0.busy) n++;
    end
    chk("midrst_no_done", 240'(n), 240'(0));
    chk("midrst_y_held", 240'(io0.y), 240'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
